norm1_mul_pipe: RTL
===================

Name: norm1_mul_pipe

Overview:
- Parametrised, pipelined signed/unsigned multiplier for the norm1 (LRN) datapath.
- Successor to the combinational fixed-width multipliers: adds a valid/ready handshake with backpressure, a configurable stage count, a per-operation signed/unsigned mode, round-half-up right shift and output saturation.
- Sits between the squared-sum accumulator and the scale/normalise stage. Accepts one operand pair per cycle.

Parameters:
- ID, 1, instance identifier; no functional effect.
- NUM_STAGE, 3, pipeline depth in register stages (>=1). Equals latency and in-flight capacity.
- DIN0_WIDTH, 43, width of operand din0.
- DIN1_WIDTH, 25, width of operand din1.
- SHIFT, 24, arithmetic right shift applied to the full product (0..DIN0_WIDTH+DIN1_WIDTH-1).
- DOUT_WIDTH, 32, width of the saturated result.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- din0  in  DIN0_WIDTH  operand 0.
- din1  in  DIN1_WIDTH  operand 1.
- signed_mode  in  1  1 = operands are two's complement, 0 = unsigned; sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- dout  out  DOUT_WIDTH  rounded, shifted, saturated product.
- sat_flag  out  1  dout was clipped; aligned with dout.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (asynchronous, any time, including mid-stream): all stage valid bits clear; out_valid=0, dout=0, sat_flag=0, busy=0. In-flight data is discarded, not flushed. in_ready=1 from the first edge after release.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid, dout and sat_flag hold stable while out_valid && !out_ready.
- Pipeline: stages 1..NUM_STAGE, each holding a valid bit and a payload.
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage advances when out_valid=0 or out_ready=1.
  - Bubbles collapse.
  - in_ready = !valid[1] || advance[1]. It is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- Latency: exactly NUM_STAGE cycles from input transfer to out_valid when out_ready stays high. Throughput is 1 per cycle. Capacity is NUM_STAGE results.
- Ordering: strict FIFO; no drop, no duplication.
- Arithmetic, with P = DIN0_WIDTH+DIN1_WIDTH+1:
  - Each operand is extended by one bit: sign-extended if signed_mode=1, zero-extended otherwise.
  - Full product is P bits, exact.
  - If SHIFT>0, add 2^(SHIFT-1), then arithmetic right shift by SHIFT (round half toward +inf). SHIFT=0 bypasses rounding.
- Saturation:
  - Signed mode clips to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
  - Unsigned mode clips to [0, 2^DOUT_WIDTH-1].
  - sat_flag=1 iff clipping occurred.
- Multiply placement: registered at stage 1. Rounding and saturation complete by stage NUM_STAGE; internal split is free provided latency holds.
- Mode mix: signed_mode may change on every transfer; each result uses its own sampled mode.
- Simultaneous input and output transfer with a full pipeline is legal and keeps full throughput.

Test Plan:
- Basic signed: din0=50331648 (3·2^24), din1=5, signed_mode=1, out_ready=1 -> dout=15, sat_flag=0, out_valid exactly 3 cycles after the transfer.
- Rounding:
  - din0=2^23, din1=1 -> dout=1.
  - din0=-2^23, din1=1 -> dout=0.
  - din0=-2^23-1, din1=1 -> dout=-1 (0xFFFFFFFF).
  - All with sat_flag=0.
- Saturation:
  - din0=2^42-1, din1=2^24-1, signed -> dout=0x7FFFFFFF, sat_flag=1.
  - din0=-2^42, din1=2^24-1 -> dout=0x80000000, sat_flag=1.
- Unsigned mode:
  - din0=2^43-1, din1=1, signed_mode=0 -> dout=524288, sat_flag=0.
  - Same operands with signed_mode=1 (din0 reads as -1) -> dout=0.
- Backpressure:
  - Stream 8 back-to-back pairs (din0=k·2^24, din1=1, k=1..8).
  - Hold out_ready=0 for 6 cycles after the first out_valid.
  - Required: in_ready drops once 3 results are held; dout 1..8 in order; no loss; dout stable while stalled.
- Reset mid-stream: assert ap_rst_n=0 asynchronously with 2 items in flight -> out_valid, busy and dout go to 0 immediately. After release no stale result appears, and the next input yields its correct result after 3 cycles.

Source files
------------

// File: rtl/norm1_mul_pipe.sv
// ----------------------------------------------------------------------------
// norm1_mul_pipe
// Pipelined signed/unsigned multiplier for the norm1 (LRN) datapath with a
// valid/ready handshake, round-half-up right shift and output saturation.
//
// Ports:
//   ap_clk       clock, all state on rising edge
//   ap_rst_n     asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     block can accept an operand pair (combinational from out_ready)
//   din0, din1   operands
//   signed_mode  1 = two's complement operands, 0 = unsigned; sampled with operands
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   dout         rounded, shifted, saturated product
//   sat_flag     dout was clipped; aligned with dout
//   busy         OR of all stage valid bits
//
// Structure: stage 1 registers the exact product. Stages 2..NUM_STAGE-1 carry
// it forward. Rounding and saturation are folded into the load of the last
// stage, so dout/sat_flag come straight from flops. With NUM_STAGE=1 the whole
// computation feeds the single stage directly.
// ----------------------------------------------------------------------------
module norm1_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int DIN0_WIDTH = 43,
    parameter int DIN1_WIDTH = 25,
    parameter int SHIFT      = 24,
    parameter int DOUT_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  sat_flag,
    output logic                  busy
);

    // ID is informational only; the zero term keeps it referenced.
    localparam int NS    = NUM_STAGE + (ID - ID);
    localparam int P     = DIN0_WIDTH + DIN1_WIDTH + 1;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int W     = P + 1;
    localparam int SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [W-1:0] RND  = (SHIFT > 0) ? (W'(1) << SH_M1) : W'(0);
    localparam logic signed [W-1:0] SMAX = {{(W-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {{(W-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
    localparam logic signed [W-1:0] UMAX = {{(W-DOUT_WIDTH){1'b0}}, {DOUT_WIDTH{1'b1}}};
    localparam logic signed [W-1:0] ZERO = {W{1'b0}};

    // Round half toward +inf, arithmetic shift, then clip to the mode's range.
    // Returns {sat, value}.
    function automatic logic [DOUT_WIDTH:0] rnd_sat(input logic signed [P-1:0] prod,
                                                    input logic              mode);
        logic signed [W-1:0] ext;
        logic signed [W-1:0] sh;
        logic [DOUT_WIDTH:0] res;
        ext = {prod[P-1], prod};
        sh  = (ext + RND) >>> SHIFT;
        if (mode) begin
            if (sh > SMAX) begin
                res = {1'b1, SMAX[DOUT_WIDTH-1:0]};
            end else if (sh < SMIN) begin
                res = {1'b1, SMIN[DOUT_WIDTH-1:0]};
            end else begin
                res = {1'b0, sh[DOUT_WIDTH-1:0]};
            end
        end else begin
            if (sh > UMAX) begin
                res = {1'b1, UMAX[DOUT_WIDTH-1:0]};
            end else if (sh < ZERO) begin
                res = {1'b1, ZERO[DOUT_WIDTH-1:0]};
            end else begin
                res = {1'b0, sh[DOUT_WIDTH-1:0]};
            end
        end
        return res;
    endfunction

    logic [NS:1]             valid_q, valid_d;
    logic [NS:1]             rdy_s;
    logic signed [P-1:0]     op0_s, op1_s, prod_in_s;
    logic signed [P-1:0]     fin_prod_s;
    logic                    fin_mode_s;
    logic                    fin_vld_s;
    logic [DOUT_WIDTH:0]     rs_s;
    logic [DOUT_WIDTH-1:0]   dout_q, dout_d;
    logic                    sat_q, sat_d;

    // Operand extension by one bit (sign or zero) and exact P-bit product.
    always_comb begin
        op0_s = {(P){1'b0}};
        op1_s = {(P){1'b0}};
        if (signed_mode) begin
            op0_s = {{(P-DIN0_WIDTH){din0[DIN0_WIDTH-1]}}, din0};
            op1_s = {{(P-DIN1_WIDTH){din1[DIN1_WIDTH-1]}}, din1};
        end else begin
            op0_s = {{(P-DIN0_WIDTH){1'b0}}, din0};
            op1_s = {{(P-DIN1_WIDTH){1'b0}}, din1};
        end
        prod_in_s = op0_s * op1_s;
    end

    // Ready chain from the output back to stage 1: a stage can load when it
    // is empty or its content moves on this cycle, so bubbles collapse.
    always_comb begin
        logic r;
        rdy_s = {NS{1'b0}};
        r = !valid_q[NS] || out_ready;
        rdy_s[NS] = r;
        for (int k = NS - 1; k >= 1; k--) begin
            r = !valid_q[k] || r;
            rdy_s[k] = r;
        end
    end

    // Next-state of the per-stage valid bits.
    always_comb begin
        valid_d = valid_q;
        if (rdy_s[1]) begin
            valid_d[1] = in_valid;
        end else begin
            valid_d[1] = valid_q[1];
        end
        for (int k = 2; k <= NS; k++) begin
            if (rdy_s[k]) begin
                valid_d[k] = valid_q[k-1];
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    generate
        if (NS == 1) begin : g_single
            assign fin_prod_s = prod_in_s;
            assign fin_mode_s = signed_mode;
            assign fin_vld_s  = in_valid;
        end else begin : g_multi
            logic signed [P-1:0] prod_q [1:NS-1];
            logic signed [P-1:0] prod_d [1:NS-1];
            logic [NS-1:1]       mode_q, mode_d;

            // Product/mode payload shift for stages 1..NS-1.
            always_comb begin
                prod_d = prod_q;
                mode_d = mode_q;
                if (rdy_s[1] && in_valid) begin
                    prod_d[1] = prod_in_s;
                    mode_d[1] = signed_mode;
                end else begin
                    prod_d[1] = prod_q[1];
                    mode_d[1] = mode_q[1];
                end
                for (int k = 2; k <= NS - 1; k++) begin
                    if (rdy_s[k] && valid_q[k-1]) begin
                        prod_d[k] = prod_q[k-1];
                        mode_d[k] = mode_q[k-1];
                    end else begin
                        prod_d[k] = prod_q[k];
                        mode_d[k] = mode_q[k];
                    end
                end
            end

            // Payload registers for stages 1..NS-1.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int k = 1; k <= NS - 1; k++) begin
                        prod_q[k] <= {(P){1'b0}};
                    end
                    mode_q <= {(NS-1){1'b0}};
                end else begin
                    prod_q <= prod_d;
                    mode_q <= mode_d;
                end
            end

            assign fin_prod_s = prod_q[NS-1];
            assign fin_mode_s = mode_q[NS-1];
            assign fin_vld_s  = valid_q[NS-1];
        end
    endgenerate

    assign rs_s = rnd_sat(fin_prod_s, fin_mode_s);

    // Last-stage payload: loads only when new data arrives, holds otherwise
    // (which keeps dout/sat_flag stable under backpressure).
    always_comb begin
        dout_d = dout_q;
        sat_d  = sat_q;
        if (rdy_s[NS] && fin_vld_s) begin
            dout_d = rs_s[DOUT_WIDTH-1:0];
            sat_d  = rs_s[DOUT_WIDTH];
        end else begin
            dout_d = dout_q;
            sat_d  = sat_q;
        end
    end

    // Stage valid bits and final result registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            valid_q <= {NS{1'b0}};
            dout_q  <= {DOUT_WIDTH{1'b0}};
            sat_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            dout_q  <= dout_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = rdy_s[1];
    assign out_valid = valid_q[NS];
    assign dout      = dout_q;
    assign sat_flag  = sat_q;
    assign busy      = |valid_q;

endmodule
